// File: rtl/sensor_depacketizer_if.sv
// Byte-stream input and decoded-sample output bundle of the sensor depacketizer.
// slave = depacketizer side, master = byte source / consumer of samples.
interface sensor_depacketizer_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [15:0]      sensor_data;
    logic             data_valid;
    logic             frame_err;
    logic             timeout_err;
    logic             busy;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;

    modport slave (
        input  rx_data, rx_valid,
        output sensor_data, data_valid, frame_err, timeout_err, busy, pkt_count, err_count
    );

    modport master (
        output rx_data, rx_valid,
        input  sensor_data, data_valid, frame_err, timeout_err, busy, pkt_count, err_count
    );
endinterface

// File: rtl/sensor_depacketizer.sv
// Parses {HEADER, SENSOR_ID, DATA_HI, DATA_LO} frames from a UART byte stream,
// emits the 16-bit sample with a one-cycle strobe and keeps saturating status counters.
module sensor_depacketizer #(
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter logic [7:0]  SENSOR_ID      = 8'h01,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter int          CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sensor_depacketizer_if.slave bus
);
    typedef enum logic [1:0] {HUNT, GOT_HDR, GOT_ID, GOT_HI} state_t;

    state_t           state_q, state_d;
    logic [7:0]       hi_q, hi_d;
    logic [15:0]      tmo_q, tmo_d;
    logic [15:0]      sample_q, sample_d;
    logic             dv_q, dv_d;
    logic             fe_q, fe_d;
    logic             te_q, te_d;
    logic             busy_q;
    logic [CNT_W-1:0] pkt_q, err_q;
    logic             pkt_inc, err_inc;

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        tmo_d    = tmo_q;
        sample_d = sample_q;
        dv_d     = 1'b0;
        fe_d     = 1'b0;
        te_d     = 1'b0;
        pkt_inc  = 1'b0;
        err_inc  = 1'b0;
        if (bus.rx_valid) begin
            // A byte always beats a timeout expiring in the same cycle.
            tmo_d = '0;
            unique case (state_q)
                HUNT: begin
                    if (bus.rx_data == HEADER) state_d = GOT_HDR;
                end
                GOT_HDR: begin
                    if (bus.rx_data == SENSOR_ID) begin
                        state_d = GOT_ID;
                    end else begin
                        fe_d    = 1'b1;
                        err_inc = 1'b1;
                        // A fresh header restarts the frame instead of being dropped.
                        state_d = (bus.rx_data == HEADER) ? GOT_HDR : HUNT;
                    end
                end
                GOT_ID: begin
                    hi_d    = bus.rx_data;
                    state_d = GOT_HI;
                end
                GOT_HI: begin
                    sample_d = {hi_q, bus.rx_data};
                    dv_d     = 1'b1;
                    pkt_inc  = 1'b1;
                    state_d  = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT) begin
            if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
                te_d    = 1'b1;
                err_inc = 1'b1;
                state_d = HUNT;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HUNT;
            hi_q     <= '0;
            tmo_q    <= '0;
            sample_q <= '0;
            dv_q     <= 1'b0;
            fe_q     <= 1'b0;
            te_q     <= 1'b0;
            busy_q   <= 1'b0;
            pkt_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            tmo_q    <= tmo_d;
            sample_q <= sample_d;
            dv_q     <= dv_d;
            fe_q     <= fe_d;
            te_q     <= te_d;
            busy_q   <= (state_d != HUNT);
            if (pkt_inc && pkt_q != '1) pkt_q <= pkt_q + 1'b1;
            if (err_inc && err_q != '1) err_q <= err_q + 1'b1;
        end
    end

    assign bus.sensor_data = sample_q;
    assign bus.data_valid  = dv_q;
    assign bus.frame_err   = fe_q;
    assign bus.timeout_err = te_q;
    assign bus.busy        = busy_q;
    assign bus.pkt_count   = pkt_q;
    assign bus.err_count   = err_q;
endmodule

// File: tb/tb_sensor_depacketizer.sv
// Directed bench for sensor_depacketizer, built with an 8-cycle timeout so expiry is quick to reach.
module tb_sensor_depacketizer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sensor_depacketizer_if #(.CNT_W(8)) bus ();

    sensor_depacketizer #(
        .HEADER(8'hAA), .SENSOR_ID(8'h01), .TIMEOUT_CYCLES(16'd8), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; on return outputs reflect that byte.
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        reset        = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("rst_sd",   bus.sensor_data, 16'h0000);
        chk("rst_dv",   bus.data_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_pkt",  bus.pkt_count, 8'd0);
        chk("rst_err",  bus.err_count, 8'd0);

        // 1: basic frame, back-to-back bytes
        send(8'hAA); send(8'h01); send(8'h12);
        chk("t1_busy", bus.busy, 1'b1);
        chk("t1_dv_early", bus.data_valid, 1'b0);
        send(8'h34);
        chk("t1_dv", bus.data_valid, 1'b1);
        chk("t1_sd", bus.sensor_data, 16'h1234);
        chk("t1_pkt", bus.pkt_count, 8'd1);
        chk("t1_fe", bus.frame_err, 1'b0);
        chk("t1_te", bus.timeout_err, 1'b0);
        chk("t1_busy_end", bus.busy, 1'b0);
        idle(1);
        chk("t1_dv_pulse", bus.data_valid, 1'b0);
        chk("t1_sd_hold", bus.sensor_data, 16'h1234);

        // 2: garbage before header is silently dropped
        send(8'h55); send(8'h00); send(8'hFF);
        chk("t2_busy", bus.busy, 1'b0);
        chk("t2_fe", bus.frame_err, 1'b0);
        send(8'hAA); send(8'h01); send(8'hAB); send(8'hCD);
        chk("t2_sd", bus.sensor_data, 16'hABCD);
        chk("t2_dv", bus.data_valid, 1'b1);
        chk("t2_err", bus.err_count, 8'd0);
        chk("t2_pkt", bus.pkt_count, 8'd2);

        // 3: bad sensor id, then a good frame
        send(8'hAA); send(8'h02);
        chk("t3_fe", bus.frame_err, 1'b1);
        chk("t3_err", bus.err_count, 8'd1);
        chk("t3_busy", bus.busy, 1'b0);
        idle(1);
        chk("t3_fe_pulse", bus.frame_err, 1'b0);
        send(8'hAA); send(8'h01); send(8'h00); send(8'h01);
        chk("t3_sd", bus.sensor_data, 16'h0001);
        chk("t3_pkt", bus.pkt_count, 8'd3);

        // 4: repeated header resyncs
        send(8'hAA); send(8'hAA);
        chk("t4_fe", bus.frame_err, 1'b1);
        chk("t4_busy", bus.busy, 1'b1);
        send(8'h01);
        chk("t4_fe_pulse", bus.frame_err, 1'b0);
        send(8'h56); send(8'h78);
        chk("t4_sd", bus.sensor_data, 16'h5678);
        chk("t4_err", bus.err_count, 8'd2);
        chk("t4_pkt", bus.pkt_count, 8'd4);

        // 5: timeout after 8 idle cycles
        send(8'hAA); send(8'h01); send(8'h12);
        idle(7);
        chk("t5_te_early", bus.timeout_err, 1'b0);
        chk("t5_busy_wait", bus.busy, 1'b1);
        idle(1);
        chk("t5_te", bus.timeout_err, 1'b1);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_err", bus.err_count, 8'd3);
        idle(1);
        chk("t5_te_pulse", bus.timeout_err, 1'b0);
        send(8'hAA); send(8'h01); send(8'hAA); send(8'hAA);
        chk("t5_sd", bus.sensor_data, 16'hAAAA);
        chk("t5_pkt", bus.pkt_count, 8'd5);
        // byte on idle cycle 8 wins over the timeout
        send(8'hAA); send(8'h01); send(8'h12);
        idle(7);
        send(8'h34);
        chk("t5b_te", bus.timeout_err, 1'b0);
        chk("t5b_dv", bus.data_valid, 1'b1);
        chk("t5b_sd", bus.sensor_data, 16'h1234);
        chk("t5b_err", bus.err_count, 8'd3);
        idle(10);
        chk("t5b_te_idle", bus.timeout_err, 1'b0);
        chk("t5b_err_idle", bus.err_count, 8'd3);

        // 6: reset mid-frame discards the partial frame
        send(8'hAA); send(8'h01);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("t6_busy", bus.busy, 1'b0);
        chk("t6_pkt", bus.pkt_count, 8'd0);
        chk("t6_err", bus.err_count, 8'd0);
        chk("t6_sd", bus.sensor_data, 16'h0000);
        send(8'h99); send(8'h88);
        chk("t6_dv", bus.data_valid, 1'b0);
        chk("t6_busy2", bus.busy, 1'b0);
        send(8'hAA); send(8'h01); send(8'h00); send(8'hFF);
        chk("t6_sd2", bus.sensor_data, 16'h00FF);
        chk("t6_pkt2", bus.pkt_count, 8'd1);

        // 7: counters saturate at all-ones
        for (int i = 0; i < 260; i++) begin
            send(8'hAA); send(8'h01); send(8'h00); send(8'h01);
        end
        chk("sat_pkt", bus.pkt_count, 8'hFF);
        for (int i = 0; i < 260; i++) begin
            send(8'hAA); send(8'h02);
        end
        chk("sat_err", bus.err_count, 8'hFF);
        chk("sat_pkt_hold", bus.pkt_count, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
